// File: rtl/guess_entry.sv
// Guess producer: synchronises and debounces the key, range-checks the switch letter code,
// and emits single-cycle accept/repeat/bad strobes while tracking the letters used this game.
module guess_entry #(
  parameter int unsigned CODE_W          = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [CODE_W-1:0] letter_code,
  input  logic              key_n,
  input  logic              enable,
  input  logic              clear_used,
  output logic [CODE_W-1:0] guess,
  output logic              guess_valid,
  output logic              repeat_flag,
  output logic              bad_code,
  output logic [25:0]       used_mask,
  output logic [4:0]        used_count
);

  localparam int unsigned NUM_LETTERS = 26;
  localparam logic [CODE_W-1:0] CODE_LO  = CODE_W'(10);
  localparam logic [CODE_W-1:0] CODE_HI  = CODE_W'(35);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                decide, decide_n;
  logic [CODE_W-1:0]   code_lat, code_lat_n;
  logic                key_m, key_s;
  logic [CODE_W-1:0]   code_m, code_s;
  logic [1:0]          sync_vld;
  logic                armed;

  // Two-flop synchronisers. 'armed' blocks a key still held through reset from
  // starting a press until a genuine high level has been seen after reset.
  always_ff @(posedge clk) begin
    if (resetn) begin
      key_m    <= 1'b1;
      key_s    <= 1'b1;
      code_m   <= '0;
      code_s   <= '0;
      sync_vld <= '0;
      armed    <= 1'b0;
    end else begin
      key_m    <= key_n;
      key_s    <= key_m;
      code_m   <= letter_code;
      code_s   <= code_m;
      sync_vld <= {sync_vld[0], 1'b1};
      if (sync_vld[1] && key_s) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      decide   <= 1'b0;
      code_lat <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      decide   <= decide_n;
      code_lat <= code_lat_n;
    end
  end

  // Debounce FSM: one 'decide' pulse per physical press.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    decide_n   = 1'b0;
    code_lat_n = code_lat;
    case (state)
      IDLE: begin
        if (!key_s && armed) begin
          state_n = PRESS_DB;
          cnt_n   = '0;
        end
      end
      PRESS_DB: begin
        if (key_s) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n    = HELD;
          cnt_n      = '0;
          decide_n   = 1'b1;
          code_lat_n = code_s;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (key_s) begin
          state_n = REL_DB;
          cnt_n   = '0;
        end
      end
      REL_DB: begin
        if (!key_s) begin
          state_n = HELD;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  logic                   in_range_c;
  logic [CODE_W-1:0]      idx_c;
  logic [NUM_LETTERS-1:0] letter_bit_c;
  logic                   used_hit_c;
  logic                   accept_c;

  // Index is only meaningful once the code is known to be in range.
  always_comb begin
    in_range_c   = (code_lat >= CODE_LO) && (code_lat <= CODE_HI);
    idx_c        = code_lat - CODE_LO;
    letter_bit_c = in_range_c ? (NUM_LETTERS'(1) << idx_c) : '0;
    used_hit_c   = |(used_mask & letter_bit_c);
    accept_c     = decide && enable && in_range_c && !used_hit_c;
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      guess       <= '0;
      guess_valid <= 1'b0;
      repeat_flag <= 1'b0;
      bad_code    <= 1'b0;
      used_mask   <= '0;
      used_count  <= '0;
    end else begin
      guess_valid <= 1'b0;
      repeat_flag <= 1'b0;
      bad_code    <= 1'b0;
      if (decide && enable) begin
        if (!in_range_c) begin
          bad_code <= 1'b1;
        end else if (used_hit_c) begin
          repeat_flag <= 1'b1;
        end else begin
          guess_valid <= 1'b1;
          guess       <= code_lat;
        end
      end
      // New-game clear wins over the bit set by a coincident acceptance.
      if (clear_used) begin
        used_mask  <= '0;
        used_count <= '0;
      end else if (accept_c) begin
        used_mask  <= used_mask | letter_bit_c;
        used_count <= used_count + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_guess_entry.sv
// Directed bench for guess_entry with a short debounce window; expected values are
// hand-derived from the press-to-strobe timing and the letter-index mapping.
module tb_guess_entry;

  localparam int unsigned CODE_W = 6;
  localparam int unsigned DB     = 4;

  logic              clk = 1'b0;
  logic              resetn;
  logic [CODE_W-1:0] letter_code;
  logic              key_n;
  logic              enable;
  logic              clear_used;
  logic [CODE_W-1:0] guess;
  logic              guess_valid;
  logic              repeat_flag;
  logic              bad_code;
  logic [25:0]       used_mask;
  logic [4:0]        used_count;

  int n_chk  = 0;
  int n_pass = 0;
  int n_gv, n_rf, n_bc, first_gv;

  guess_entry #(.CODE_W(CODE_W), .DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .letter_code (letter_code),
    .key_n       (key_n),
    .enable      (enable),
    .clear_used  (clear_used),
    .guess       (guess),
    .guess_valid (guess_valid),
    .repeat_flag (repeat_flag),
    .bad_code    (bad_code),
    .used_mask   (used_mask),
    .used_count  (used_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] low_for(input int n);
    return ~((64'd1 << n) - 64'd1);
  endfunction

  // pat[i] is key_n before edge i; code switches to c2 at cycle chg; clear_used high at edge clr_at.
  task automatic run_press(input logic [63:0] pat, input int len, input logic [5:0] c,
                           input logic [5:0] c2, input int chg, input int clr_at);
    n_gv = 0; n_rf = 0; n_bc = 0; first_gv = -1;
    letter_code = c;
    for (int i = 0; i < len + 14; i++) begin
      key_n = (i < len) ? pat[i] : 1'b1;
      if (i == chg) letter_code = c2;
      clear_used = (i == clr_at);
      tick;
      if (guess_valid) begin
        n_gv++;
        if (first_gv < 0) first_gv = i;
      end
      if (repeat_flag) n_rf++;
      if (bad_code) n_bc++;
    end
    clear_used = 1'b0;
  endtask

  logic [25:0] exp_mask;

  initial begin
    resetn = 1'b1; key_n = 1'b1; letter_code = '0; enable = 1'b1; clear_used = 1'b0;
    repeat (3) tick;
    check("rst_guess", 32'(guess), 32'h0);
    check("rst_strobes", 32'({guess_valid, repeat_flag, bad_code}), 32'h0);
    check("rst_mask", 32'(used_mask), 32'h0);
    check("rst_count", 32'(used_count), 32'h0);
    resetn = 1'b0;
    repeat (5) tick;

    // Step 1: clean press of 6'h1C
    run_press(low_for(10), 10, 6'h1C, 6'h1C, -1, -1);
    exp_mask = 26'(1) << 18;
    check("s1_latency", 32'(first_gv), 32'd7);
    check("s1_gv_count", 32'(n_gv), 32'd1);
    check("s1_guess", 32'(guess), 32'h1C);
    check("s1_mask", 32'(used_mask), 32'(exp_mask));
    check("s1_count", 32'(used_count), 32'd1);

    // Step 2: same letter again
    run_press(low_for(10), 10, 6'h1C, 6'h1C, -1, -1);
    check("s2_repeat", 32'(n_rf), 32'd1);
    check("s2_no_gv", 32'(n_gv), 32'd0);
    check("s2_guess", 32'(guess), 32'h1C);
    check("s2_count", 32'(used_count), 32'd1);

    // Step 3: bounce (low 2, high 1, low 2, high), then a clean 6-cycle press
    run_press(64'hFFFF_FFFF_FFFF_FFE4, 5, 6'h0C, 6'h0C, -1, -1);
    check("s3_bounce_quiet", 32'(n_gv + n_rf + n_bc), 32'd0);
    run_press(low_for(6), 6, 6'h0C, 6'h0C, -1, -1);
    exp_mask |= 26'(1) << 2;
    check("s3_clean_gv", 32'(n_gv), 32'd1);
    check("s3_clean_latency", 32'(first_gv), 32'd7);
    check("s3_mask", 32'(used_mask), 32'(exp_mask));

    // Step 4: out-of-range codes on both sides, then the top legal code
    run_press(low_for(10), 10, 6'h05, 6'h05, -1, -1);
    check("s4_bad_low", 32'(n_bc), 32'd1);
    check("s4_bad_low_gv", 32'(n_gv), 32'd0);
    run_press(low_for(10), 10, 6'h24, 6'h24, -1, -1);
    check("s4_bad_high", 32'(n_bc), 32'd1);
    check("s4_mask_kept", 32'(used_mask), 32'(exp_mask));
    run_press(low_for(10), 10, 6'h23, 6'h23, -1, -1);
    exp_mask |= 26'(1) << 25;
    check("s4_z_gv", 32'(n_gv), 32'd1);
    check("s4_z_mask", 32'(used_mask), 32'(exp_mask));

    // Step 5: long hold with code change mid-hold
    run_press(low_for(50), 50, 6'h0A, 6'h0B, 20, -1);
    exp_mask |= 26'(1) << 0;
    check("s5_one_gv", 32'(n_gv), 32'd1);
    check("s5_guess", 32'(guess), 32'h0A);
    check("s5_mask", 32'(used_mask), 32'(exp_mask));
    check("s5_count", 32'(used_count), 32'd4);

    // Step 6: disabled press, then clear coinciding with acceptance
    enable = 1'b0;
    run_press(low_for(10), 10, 6'h0D, 6'h0D, -1, -1);
    check("s6_disabled_quiet", 32'(n_gv + n_rf + n_bc), 32'd0);
    check("s6_disabled_count", 32'(used_count), 32'd4);
    enable = 1'b1;
    run_press(low_for(10), 10, 6'h22, 6'h22, -1, 7);
    check("s6_clr_gv", 32'(n_gv), 32'd1);
    check("s6_clr_latency", 32'(first_gv), 32'd7);
    check("s6_clr_guess", 32'(guess), 32'h22);
    check("s6_clr_mask", 32'(used_mask), 32'h0);
    check("s6_clr_count", 32'(used_count), 32'd0);

    // Reset while HELD, key kept low through and after reset
    letter_code = 6'h0E;
    key_n = 1'b0;
    repeat (10) tick;
    resetn = 1'b1;
    tick;
    resetn = 1'b0;
    n_gv = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (guess_valid) n_gv++;
    end
    check("rh_no_gv", 32'(n_gv), 32'd0);
    check("rh_guess", 32'(guess), 32'h0);
    check("rh_mask", 32'(used_mask), 32'h0);
    check("rh_count", 32'(used_count), 32'd0);
    key_n = 1'b1;
    repeat (4) tick;
    run_press(low_for(10), 10, 6'h0E, 6'h0E, -1, -1);
    check("rh_repress_gv", 32'(n_gv), 32'd1);
    check("rh_repress_guess", 32'(guess), 32'h0E);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
